// File: rtl/jk_pkg.sv
// Shared mode encoding for the jk_flop_bank cell array.
package jk_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_JK = 2'd0;
  localparam mode_t MODE_D  = 2'd1;
  localparam mode_t MODE_T  = 2'd2;
  localparam mode_t MODE_SR = 2'd3;

endpackage

// File: rtl/jk_cell.sv
// One flip-flop cell: combinational next state for the selected mode, plus an
// SR illegal-input (S=R=1) indication. The state register lives in the bank.
module jk_cell
  import jk_pkg::*;
(
  input  mode_t i_mode,
  input  logic  i_j,
  input  logic  i_k,
  input  logic  i_q,
  output logic  o_q_next,
  output logic  o_sr_illegal
);

  // NOTE: every output of an always_comb gets a default first, so no path
  // through the case statements can leave it unassigned and infer a latch.
  always_comb begin
    o_q_next     = i_q;
    o_sr_illegal = 1'b0;
    case (i_mode)
      MODE_JK: begin
        case ({i_j, i_k})
          2'b01:   o_q_next = 1'b0;
          2'b10:   o_q_next = 1'b1;
          2'b11:   o_q_next = ~i_q;
          default: o_q_next = i_q;
        endcase
      end
      MODE_D: o_q_next = i_j;
      MODE_T: o_q_next = i_q ^ i_j;
      MODE_SR: begin
        case ({i_j, i_k})
          2'b10:   o_q_next = 1'b1;
          2'b01:   o_q_next = 1'b0;
          2'b11:   o_sr_illegal = 1'b1;
          default: o_q_next = i_q;
        endcase
      end
      default: o_q_next = i_q;
    endcase
  end

endmodule

// File: rtl/jk_flop_bank.sv
// Bank of WIDTH mode-selectable flip-flop cells with global enable, change
// pulse, saturating change counter and sticky SR-illegal flag.
module jk_flop_bank
  import jk_pkg::*;
#(
  parameter int                 WIDTH     = 8,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0,
  parameter int                 CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  mode_t            mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic             clr_cnt,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             changed,
  output logic [CNT_W-1:0] cnt,
  output logic             err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_q;
  logic             r_changed;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  logic [WIDTH-1:0] w_q_next;
  logic [WIDTH-1:0] w_sr_illegal;
  logic             w_change;

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    jk_cell u_cell (
      .i_mode       (mode),
      .i_j          (j[g]),
      .i_k          (k[g]),
      .i_q          (r_q[g]),
      .o_q_next     (w_q_next[g]),
      .o_sr_illegal (w_sr_illegal[g])
    );
  end

  assign w_change = (w_q_next != r_q);

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q       <= RESET_VAL;
      r_changed <= 1'b0;
      r_cnt     <= '0;
      r_err     <= 1'b0;
    end else begin
      if (en) begin
        r_q       <= w_q_next;
        r_changed <= w_change;
      end else begin
        r_changed <= 1'b0;
      end

      // clr_cnt wins over a same-edge change or SR-illegal event.
      if (clr_cnt) begin
        r_cnt <= '0;
        r_err <= 1'b0;
      end else if (en) begin
        if (w_change && (r_cnt != CNT_MAX)) r_cnt <= r_cnt + CNT_ONE;
        if (|w_sr_illegal)                  r_err <= 1'b1;
      end
    end
  end

  assign q       = r_q;
  assign qbar    = ~r_q;
  assign changed = r_changed;
  assign cnt     = r_cnt;
  assign err     = r_err;

endmodule

// File: tb/tb_jk_flop_bank.sv
// Directed self-checking bench for jk_flop_bank (WIDTH=8, RESET_VAL=A5, CNT_W=4).
module tb_jk_flop_bank;
  import jk_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  mode_t      mode;
  logic [7:0] j;
  logic [7:0] k;
  logic       clr_cnt;
  logic [7:0] q;
  logic [7:0] qbar;
  logic       changed;
  logic [3:0] cnt;
  logic       err;

  int n_checks = 0;
  int n_fail   = 0;

  jk_flop_bank #(
    .WIDTH     (8),
    .RESET_VAL (8'hA5),
    .CNT_W     (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .mode    (mode),
    .j       (j),
    .k       (k),
    .clr_cnt (clr_cnt),
    .q       (q),
    .qbar    (qbar),
    .changed (changed),
    .cnt     (cnt),
    .err     (err)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic e, input mode_t m, input logic [7:0] jv,
                       input logic [7:0] kv, input logic c);
    en = e; mode = m; j = jv; k = kv; clr_cnt = c;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, MODE_JK, 8'h00, 8'h00, 1'b0);
    step(2);
    rst = 1'b0;
    n_checks++; if (q !== 8'hA5)    begin n_fail++; $display("FAIL reset_q: got %h expected a5", q); end
    n_checks++; if (qbar !== 8'h5A) begin n_fail++; $display("FAIL reset_qbar: got %h expected 5a", qbar); end
    n_checks++; if (changed !== 1'b0) begin n_fail++; $display("FAIL reset_changed: got %b expected 0", changed); end
    n_checks++; if (cnt !== 4'h0)   begin n_fail++; $display("FAIL reset_cnt: got %h expected 0", cnt); end
    n_checks++; if (err !== 1'b0)   begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
  endtask

  task automatic test_jk();
    drive(1'b1, MODE_JK, 8'hF0, 8'h0F, 1'b0); step();
    n_checks++; if (q !== 8'hF0)      begin n_fail++; $display("FAIL jk_set_q: got %h expected f0", q); end
    n_checks++; if (changed !== 1'b1) begin n_fail++; $display("FAIL jk_set_changed: got %b expected 1", changed); end
    n_checks++; if (cnt !== 4'h1)     begin n_fail++; $display("FAIL jk_set_cnt: got %h expected 1", cnt); end
    drive(1'b1, MODE_JK, 8'hFF, 8'hFF, 1'b0); step();
    n_checks++; if (q !== 8'h0F)      begin n_fail++; $display("FAIL jk_toggle_q: got %h expected 0f", q); end
    n_checks++; if (qbar !== 8'hF0)   begin n_fail++; $display("FAIL jk_toggle_qbar: got %h expected f0", qbar); end
    n_checks++; if (cnt !== 4'h2)     begin n_fail++; $display("FAIL jk_toggle_cnt: got %h expected 2", cnt); end
    drive(1'b1, MODE_JK, 8'h00, 8'h00, 1'b0); step();
    n_checks++; if (q !== 8'h0F)      begin n_fail++; $display("FAIL jk_hold_q: got %h expected 0f", q); end
    n_checks++; if (changed !== 1'b0) begin n_fail++; $display("FAIL jk_hold_changed: got %b expected 0", changed); end
    n_checks++; if (cnt !== 4'h2)     begin n_fail++; $display("FAIL jk_hold_cnt: got %h expected 2", cnt); end
  endtask

  task automatic test_d_t_enable();
    drive(1'b1, MODE_D, 8'h3C, 8'hFF, 1'b0); step();
    n_checks++; if (q !== 8'h3C)  begin n_fail++; $display("FAIL d_q: got %h expected 3c", q); end
    n_checks++; if (cnt !== 4'h3) begin n_fail++; $display("FAIL d_cnt: got %h expected 3", cnt); end
    drive(1'b1, MODE_T, 8'hFF, 8'h00, 1'b0); step();
    n_checks++; if (q !== 8'hC3)  begin n_fail++; $display("FAIL t_q: got %h expected c3", q); end
    n_checks++; if (cnt !== 4'h4) begin n_fail++; $display("FAIL t_cnt: got %h expected 4", cnt); end
    drive(1'b0, MODE_T, 8'hFF, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (q !== 8'hC3)      begin n_fail++; $display("FAIL en_off_q[%0d]: got %h expected c3", i, q); end
      n_checks++; if (changed !== 1'b0) begin n_fail++; $display("FAIL en_off_changed[%0d]: got %b expected 0", i, changed); end
      n_checks++; if (cnt !== 4'h4)     begin n_fail++; $display("FAIL en_off_cnt[%0d]: got %h expected 4", i, cnt); end
    end
  endtask

  task automatic test_sr();
    drive(1'b1, MODE_D, 8'h00, 8'h00, 1'b0); step();
    n_checks++; if (q !== 8'h00)  begin n_fail++; $display("FAIL sr_prep_q: got %h expected 00", q); end
    n_checks++; if (cnt !== 4'h5) begin n_fail++; $display("FAIL sr_prep_cnt: got %h expected 5", cnt); end
    drive(1'b1, MODE_SR, 8'h01, 8'h01, 1'b0); step();
    n_checks++; if (q !== 8'h00)      begin n_fail++; $display("FAIL sr_illegal_q: got %h expected 00", q); end
    n_checks++; if (err !== 1'b1)     begin n_fail++; $display("FAIL sr_illegal_err: got %b expected 1", err); end
    n_checks++; if (changed !== 1'b0) begin n_fail++; $display("FAIL sr_illegal_changed: got %b expected 0", changed); end
    drive(1'b1, MODE_SR, 8'h80, 8'h00, 1'b0); step();
    n_checks++; if (q !== 8'h80)  begin n_fail++; $display("FAIL sr_set_q: got %h expected 80", q); end
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL sr_sticky_err: got %b expected 1", err); end
    n_checks++; if (cnt !== 4'h6) begin n_fail++; $display("FAIL sr_set_cnt: got %h expected 6", cnt); end
    drive(1'b1, MODE_SR, 8'h00, 8'h01, 1'b0); step();
    n_checks++; if (q !== 8'h80)  begin n_fail++; $display("FAIL sr_reset_bit0_q: got %h expected 80", q); end
    drive(1'b1, MODE_SR, 8'h00, 8'h00, 1'b1); step();
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL sr_clr_err: got %b expected 0", err); end
    n_checks++; if (cnt !== 4'h0) begin n_fail++; $display("FAIL sr_clr_cnt: got %h expected 0", cnt); end
    n_checks++; if (q !== 8'h80)  begin n_fail++; $display("FAIL sr_clr_q: got %h expected 80", q); end
  endtask

  task automatic test_saturation();
    logic [7:0] exp_q;
    logic [3:0] exp_cnt;
    exp_q   = 8'h80;
    exp_cnt = 4'h0;
    drive(1'b1, MODE_T, 8'h01, 8'h00, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step();
      exp_q = exp_q ^ 8'h01;
      if (exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'h1;
      n_checks++; if (q !== exp_q)      begin n_fail++; $display("FAIL sat_q[%0d]: got %h expected %h", i, q, exp_q); end
      n_checks++; if (changed !== 1'b1) begin n_fail++; $display("FAIL sat_changed[%0d]: got %b expected 1", i, changed); end
      n_checks++; if (cnt !== exp_cnt)  begin n_fail++; $display("FAIL sat_cnt[%0d]: got %h expected %h", i, cnt, exp_cnt); end
    end
  endtask

  task automatic test_simultaneous();
    rst = 1'b1;
    drive(1'b1, MODE_T, 8'hFF, 8'h00, 1'b1); step();
    rst = 1'b0;
    n_checks++; if (q !== 8'hA5)      begin n_fail++; $display("FAIL rst_prio_q: got %h expected a5", q); end
    n_checks++; if (cnt !== 4'h0)     begin n_fail++; $display("FAIL rst_prio_cnt: got %h expected 0", cnt); end
    n_checks++; if (changed !== 1'b0) begin n_fail++; $display("FAIL rst_prio_changed: got %b expected 0", changed); end
    drive(1'b1, MODE_T, 8'hFF, 8'h00, 1'b0); step();
    n_checks++; if (cnt !== 4'h1) begin n_fail++; $display("FAIL pre_clr_cnt: got %h expected 1", cnt); end
    drive(1'b1, MODE_D, 8'h11, 8'h00, 1'b1); step();
    n_checks++; if (q !== 8'h11)      begin n_fail++; $display("FAIL clr_change_q: got %h expected 11", q); end
    n_checks++; if (cnt !== 4'h0)     begin n_fail++; $display("FAIL clr_change_cnt: got %h expected 0", cnt); end
    n_checks++; if (changed !== 1'b1) begin n_fail++; $display("FAIL clr_change_changed: got %b expected 1", changed); end
    drive(1'b1, MODE_SR, 8'h01, 8'h01, 1'b1); step();
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL clr_sr11_err: got %b expected 0", err); end
    n_checks++; if (q !== 8'h11)  begin n_fail++; $display("FAIL clr_sr11_q: got %h expected 11", q); end
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, MODE_JK, 8'h00, 8'h00, 1'b0);
    #1;
    test_reset();
    test_jk();
    test_d_t_enable();
    test_sr();
    test_saturation();
    test_simultaneous();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
